// File: rtl/hilo_div_if.sv
// hilo_div_if
//   Groups the HI/LO write port, the divider request/operand port and the
//   divider status outputs of hilo_div_unit into one bundle.
//   Ports (all carried as interface signals):
//     we_i, hi_i, lo_i          WB-stage HI/LO commit
//     hi_o, lo_o                architectural HI/LO registers
//     div_start_i, div_signed_i divide request and signedness
//     dividend_i, divisor_i     divide operands
//     div_annul_i               flush of the in-flight divide
//     stall_o                   hold request toward the pipeline controller
//     div_ready_o, div_zero_o   one-cycle completion pulses
//   Modports: master (pipeline side) drives requests, slave (unit side) answers.
interface hilo_div_if #(
    parameter int WIDTH = 32
);
    logic             we_i;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_start_i;
    logic             div_signed_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             div_annul_i;
    logic             stall_o;
    logic             div_ready_o;
    logic             div_zero_o;

    modport master (
        output we_i, hi_i, lo_i, div_start_i, div_signed_i,
               dividend_i, divisor_i, div_annul_i,
        input  hi_o, lo_o, stall_o, div_ready_o, div_zero_o
    );

    modport slave (
        input  we_i, hi_i, lo_i, div_start_i, div_signed_i,
               dividend_i, divisor_i, div_annul_i,
        output hi_o, lo_o, stall_o, div_ready_o, div_zero_o
    );
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit
//   Holds the architectural HI and LO registers, commits WB-stage writes and
//   runs an iterative restoring divider (DIV/DIVU) whose quotient lands in LO
//   and remainder in HI. Requests a pipeline stall while a divide is running.
//   Ports:
//     clk   pipeline clock, rising edge
//     rst   asynchronous reset, active-low
//     bus   hilo_div_if slave modport (WB write, divide request, status)
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    hilo_div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set; used for magnitudes and fixup.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] divisor_r;
    logic [CNT_W-1:0] count_r;
    logic             neg_quot_r;
    logic             neg_rem_r;
    logic             zero_r;
    logic             ready_r;
    logic             zero_pulse_r;

    logic [WIDTH:0]   rem_sh_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic [WIDTH-1:0] quot_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic             accept_s;

    // Divider datapath: one restoring step plus operand magnitudes and sign fixup.
    always_comb begin
        rem_sh_s       = {rem_r, quot_r[WIDTH-1]};
        ge_s           = (rem_sh_s >= {1'b0, divisor_r});
        // The true difference is below |divisor|, so the low WIDTH bits are exact.
        rem_next_s     = rem_sh_s[WIDTH-1:0] - divisor_r;
        dividend_mag_s = cond_negate(bus.dividend_i, bus.div_signed_i & bus.dividend_i[WIDTH-1]);
        divisor_mag_s  = cond_negate(bus.divisor_i, bus.div_signed_i & bus.divisor_i[WIDTH-1]);
        quot_fix_s     = cond_negate(quot_r, neg_quot_r);
        rem_fix_s      = cond_negate(rem_r, neg_rem_r);
        accept_s       = (state_r == IDLE) & bus.div_start_i & ~bus.div_annul_i;
    end

    // HI/LO registers, divider FSM and completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            hi_r         <= {WIDTH{1'b0}};
            lo_r         <= {WIDTH{1'b0}};
            rem_r        <= {WIDTH{1'b0}};
            quot_r       <= {WIDTH{1'b0}};
            divisor_r    <= {WIDTH{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            neg_quot_r   <= 1'b0;
            neg_rem_r    <= 1'b0;
            zero_r       <= 1'b0;
            ready_r      <= 1'b0;
            zero_pulse_r <= 1'b0;
        end else begin
            ready_r      <= 1'b0;
            zero_pulse_r <= 1'b0;
            if (bus.we_i) begin
                hi_r <= bus.hi_i;
                lo_r <= bus.lo_i;
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        quot_r     <= dividend_mag_s;
                        rem_r      <= {WIDTH{1'b0}};
                        divisor_r  <= divisor_mag_s;
                        neg_quot_r <= bus.div_signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
                        neg_rem_r  <= bus.div_signed_i & bus.dividend_i[WIDTH-1];
                        count_r    <= {CNT_W{1'b0}};
                        if (bus.divisor_i == {WIDTH{1'b0}}) begin
                            zero_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            zero_r  <= 1'b0;
                            state_r <= BUSY;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.div_annul_i) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r   <= ge_s ? rem_next_s : rem_sh_s[WIDTH-1:0];
                        quot_r  <= {quot_r[WIDTH-2:0], ge_s};
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (count_r == CNT_W'(WIDTH - 1)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= BUSY;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    if (!bus.div_annul_i) begin
                        if (zero_r) begin
                            zero_pulse_r <= 1'b1;
                        end else begin
                            // Later assignment: the divide (younger) beats a same-edge WB write.
                            hi_r    <= rem_fix_s;
                            lo_r    <= quot_fix_s;
                            ready_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi_o        = hi_r;
    assign bus.lo_o        = lo_r;
    assign bus.div_ready_o = ready_r;
    assign bus.div_zero_o  = zero_pulse_r;
    // Stall covers the request cycle itself, so EX holds from the moment a start is seen.
    assign bus.stall_o     = accept_s | (state_r == BUSY);
endmodule
